// File: rtl/serial_writer.sv
// Serial-to-parallel group writer: deserialises an asynchronous bit stream into words and writes them
// into the ping-pong buffer not being read. Optional error counter enabled by SERIAL_WRITER_ERRCNT_EN.
module serial_writer #(
  parameter int unsigned WORD_BITS = 12,
  parameter int unsigned GROUP_LEN = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iSCLK,
  input  logic                 iSFM,
  input  logic                 iSDAT,
  input  logic                 iSwitch,
  output logic [WORD_BITS-1:0] oData,
  output logic [9:0]           oAddr,
  output logic                 oWrEn0,
  output logic                 oWrEn1,
  output logic                 oGroupDone,
  output logic                 oSyncErr,
  output logic                 oCollide,
  output logic [7:0]           oErrCnt
);

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = $clog2(WORD_BITS + 1);
  localparam int unsigned ERR_W  = 8;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(GROUP_LEN - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_BITS - 1);

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_sclk_meta;
  logic                   r_sclk_sync;
  logic                   r_sclk_prev;
  logic                   r_fm_meta;
  logic                   r_fm_sync;
  logic                   r_dat_meta;
  logic                   r_dat_sync;

  logic [WORD_BITS-2:0]   r_shift;
  logic [CNT_W-1:0]       r_bitcnt;
  logic                   r_wb;

  logic                   w_bit_evt;
  logic                   w_start;
  logic                   w_sync_err;
  logic                   w_shift;
  logic                   w_word_done;
  logic                   w_wr_any;
  logic                   w_grp_done;
  logic                   w_addr_inc;
  logic                   w_collide_set;
  logic [WORD_BITS-1:0]   w_next_word;

  // Two-flop synchronizers plus a delayed copy of the bit clock for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_fm_meta   <= 1'b0;
      r_fm_sync   <= 1'b0;
      r_dat_meta  <= 1'b0;
      r_dat_sync  <= 1'b0;
    end else begin
      r_sclk_meta <= iSCLK;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_fm_meta   <= iSFM;
      r_fm_sync   <= r_fm_meta;
      r_dat_meta  <= iSDAT;
      r_dat_sync  <= r_dat_meta;
    end
  end

  assign w_bit_evt   = r_sclk_sync & ~r_sclk_prev;
  assign w_next_word = {r_shift, r_dat_sync};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a marker always (re)starts a group; the final write ends it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HUNT: begin
        if (w_start) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_start) begin
          w_state_nxt = SHIFT;
        end else if (w_grp_done) begin
          w_state_nxt = HUNT;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // Action decode for the datapath
  always_comb begin
    w_start       = 1'b0;
    w_sync_err    = 1'b0;
    w_shift       = 1'b0;
    w_word_done   = 1'b0;
    w_grp_done    = 1'b0;
    w_addr_inc    = 1'b0;
    w_collide_set = 1'b0;
    w_wr_any      = oWrEn0 | oWrEn1;
    case (r_state)
      HUNT: begin
        w_start = w_bit_evt & r_fm_sync;
      end
      SHIFT: begin
        w_start       = w_bit_evt & r_fm_sync;
        w_sync_err    = w_start;
        w_shift       = w_bit_evt & ~r_fm_sync;
        w_word_done   = w_shift & (r_bitcnt == LAST_BIT);
        w_grp_done    = w_wr_any & ~w_start & (oAddr == LAST_ADDR);
        w_addr_inc    = w_wr_any & ~w_start & (oAddr != LAST_ADDR);
        w_collide_set = (iSwitch == r_wb) & ~oCollide;
      end
      default: begin
        w_start = 1'b0;
      end
    endcase
  end

  // Word assembly, write strobes, address and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_wb       <= 1'b0;
      oData      <= '0;
      oAddr      <= '0;
      oWrEn0     <= 1'b0;
      oWrEn1     <= 1'b0;
      oGroupDone <= 1'b0;
      oSyncErr   <= 1'b0;
      oCollide   <= 1'b0;
    end else begin
      oWrEn0     <= 1'b0;
      oWrEn1     <= 1'b0;
      oGroupDone <= w_grp_done;
      oSyncErr   <= w_sync_err;
      if (w_collide_set) begin
        oCollide <= 1'b1;
      end
      if (w_start) begin
        r_shift  <= (WORD_BITS-1)'(r_dat_sync);
        r_bitcnt <= CNT_W'(1);
        r_wb     <= ~iSwitch;
        oAddr    <= '0;
      end else begin
        if (w_word_done) begin
          oData    <= w_next_word;
          r_bitcnt <= '0;
          oWrEn0   <= ~r_wb;
          oWrEn1   <= r_wb;
        end else if (w_shift) begin
          r_shift  <= w_next_word[WORD_BITS-2:0];
          r_bitcnt <= r_bitcnt + CNT_W'(1);
        end
        if (w_grp_done) begin
          oAddr <= '0;
        end else if (w_addr_inc) begin
          oAddr <= oAddr + ADDR_W'(1);
        end
      end
    end
  end

`ifdef SERIAL_WRITER_ERRCNT_EN
  logic [ERR_W-1:0] r_errcnt;
  logic [1:0]       w_err_inc;
  logic [ERR_W:0]   w_err_sum;

  // Saturating count of sync errors and collision onsets (both may land in one cycle)
  always_comb begin
    w_err_inc = {1'b0, w_sync_err} + {1'b0, w_collide_set};
    w_err_sum = (ERR_W+1)'(r_errcnt) + (ERR_W+1)'(w_err_inc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_errcnt <= '0;
    end else if (w_err_sum[ERR_W]) begin
      r_errcnt <= '1;
    end else begin
      r_errcnt <= w_err_sum[ERR_W-1:0];
    end
  end

  assign oErrCnt = r_errcnt;
`else
  assign oErrCnt = '0;
`endif

endmodule

// File: tb/tb_serial_writer.sv
// Scoreboard bench for serial_writer: stimulus pushes expected writes, a forked monitor pops and compares.
module tb_serial_writer;

  localparam int unsigned WB = 12;
  localparam int unsigned GL = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          iSCLK = 1'b0;
  logic          iSFM = 1'b0;
  logic          iSDAT = 1'b0;
  logic          iSwitch = 1'b0;
  logic [WB-1:0] oData;
  logic [9:0]    oAddr;
  logic          oWrEn0;
  logic          oWrEn1;
  logic          oGroupDone;
  logic          oSyncErr;
  logic          oCollide;
  logic [7:0]    oErrCnt;

  serial_writer #(.WORD_BITS(WB), .GROUP_LEN(GL)) dut (
    .clk        (clk),
    .reset      (reset),
    .iSCLK      (iSCLK),
    .iSFM       (iSFM),
    .iSDAT      (iSDAT),
    .iSwitch    (iSwitch),
    .oData      (oData),
    .oAddr      (oAddr),
    .oWrEn0     (oWrEn0),
    .oWrEn1     (oWrEn1),
    .oGroupDone (oGroupDone),
    .oSyncErr   (oSyncErr),
    .oCollide   (oCollide),
    .oErrCnt    (oErrCnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          bank;
    logic [9:0]    addr;
    logic [WB-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned n_wr0 = 0;
  int unsigned n_wr1 = 0;
  int unsigned n_gd = 0;
  int unsigned n_se = 0;
  int unsigned last_rise = 0;

`ifdef SERIAL_WRITER_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pops one expected write per strobe; also tallies pulses for the stimulus thread
  task automatic monitor();
    wr_t         e;
    wr_t         a;
    int unsigned lat;
    forever begin
      @(negedge clk);
      if (oWrEn0 && oWrEn1) chk("wren_exclusive", 32'({oWrEn0, oWrEn1}), 32'b01);
      if (oWrEn0 || oWrEn1) begin
        a.bank = oWrEn1;
        a.addr = oAddr;
        a.data = oData;
        lat = cyc - last_rise;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual bank=%0d addr=%0d data=0x%0h required none", a.bank, a.addr, a.data);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (a !== e) begin
            failures++;
            $display("FAIL write actual bank=%0d addr=%0d data=0x%0h required bank=%0d addr=%0d data=0x%0h",
                     a.bank, a.addr, a.data, e.bank, e.addr, e.data);
          end
          chk("strobe_latency_ok", 32'(lat >= 3 && lat <= 4), 32'd1);
        end
        if (oWrEn0) n_wr0++;
        if (oWrEn1) n_wr1++;
      end
      if (oGroupDone) n_gd++;
      if (oSyncErr) n_se++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, 32'(oData), 32'd0);
    chk({tag, "_addr"}, 32'(oAddr), 32'd0);
    chk({tag, "_wren0"}, 32'(oWrEn0), 32'd0);
    chk({tag, "_wren1"}, 32'(oWrEn1), 32'd0);
    chk({tag, "_gdone"}, 32'(oGroupDone), 32'd0);
    chk({tag, "_syncerr"}, 32'(oSyncErr), 32'd0);
    chk({tag, "_collide"}, 32'(oCollide), 32'd0);
    chk({tag, "_errcnt"}, 32'(oErrCnt), 32'd0);
  endtask

  // Asserts reset asynchronously (checked before any clock edge) and returns on a falling clk edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    iSCLK = 1'b0;
    iSFM  = 1'b0;
    iSDAT = 1'b0;
    reset = 1'b0;
    #1;
    chk_all_zero(tag);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One bit: 3 clk low with data set up, then 3 clk high
  task automatic send_bit(input logic b, input logic m);
    iSCLK = 1'b0;
    iSDAT = b;
    iSFM  = m;
    repeat (3) @(negedge clk);
    iSCLK = 1'b1;
    last_rise = cyc;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_word(input logic [WB-1:0] w, input logic mark);
    for (int i = WB - 1; i >= 0; i--) send_bit(w[i], mark && (i == WB - 1));
  endtask

  task automatic push_exp(input logic bank, input int unsigned addr, input logic [WB-1:0] data);
    wr_t e;
    e.bank = bank;
    e.addr = 10'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  int unsigned     gd0;
  int unsigned     se0;
  int unsigned     wr00;
  logic [WB-1:0]   d;
  logic [WB-1:0]   part;

  initial begin
    fork
      monitor();
    join_none

    do_reset("rst0");

    // Full group, reader on buffer 0 -> all writes to buffer 1, data equals address
    iSwitch = 1'b0;
    gd0 = n_gd; wr00 = n_wr0;
    for (int i = 0; i < int'(GL); i++) begin
      d = WB'(i);
      push_exp(1'b1, i, d);
      send_word(d, i == 0);
    end
    repeat (4) @(negedge clk);
    chk("t1_group_done", n_gd - gd0, 1);
    chk("t1_wren0_count", n_wr0 - wr00, 0);
    chk("t1_addr_wrapped", 32'(oAddr), 0);
    chk("t1_queue_drained", exp_q.size(), 0);
    chk("t1_no_collide", 32'(oCollide), 0);

    // Idle bits without a marker are ignored; reader on buffer 1 -> writes to buffer 0
    do_reset("rst1");
    iSwitch = 1'b1;
    gd0 = n_gd; wr00 = n_wr0;
    for (int i = 0; i < 8; i++) send_bit(1'(i % 3 == 0), 1'b0);
    for (int i = 0; i < int'(GL); i++) begin
      d = 12'hA5A ^ WB'(i * 37);
      push_exp(1'b0, i, d);
      send_word(d, i == 0);
    end
    repeat (4) @(negedge clk);
    chk("t2_group_done", n_gd - gd0, 1);
    chk("t2_wren0_count", n_wr0 - wr00, GL);
    chk("t2_queue_drained", exp_q.size(), 0);

    // Marker at bit 5 of word 7: partial word dropped, new group starts at address 0
    do_reset("rst2");
    iSwitch = 1'b0;
    se0 = n_se; gd0 = n_gd;
    for (int i = 0; i < 7; i++) begin
      d = 12'h800 | WB'(i);
      push_exp(1'b1, i, d);
      send_word(d, i == 0);
    end
    part = 12'hFFF;
    for (int i = WB - 1; i > WB - 6; i--) send_bit(part[i], 1'b0);
    push_exp(1'b1, 0, 12'h3C5);
    send_word(12'h3C5, 1'b1);
    repeat (4) @(negedge clk);
    chk("t3_sync_err_pulses", n_se - se0, 1);
    chk("t3_queue_drained", exp_q.size(), 0);
    chk("t3_no_group_done", n_gd - gd0, 0);
    chk("t3_errcnt", 32'(oErrCnt), ERRCNT_ON ? 32'd1 : 32'd0);

    // Reader switches onto the buffer being written mid-group
    do_reset("rst3");
    iSwitch = 1'b0;
    gd0 = n_gd;
    for (int i = 0; i < int'(GL); i++) begin
      if (i == 10) begin
        chk("t4_collide_before", 32'(oCollide), 0);
        iSwitch = 1'b1;
      end
      d = 12'hC00 ^ WB'(i * 5);
      push_exp(1'b1, i, d);
      send_word(d, i == 0);
      if (i == 10) chk("t4_collide_set", 32'(oCollide), 1);
    end
    repeat (4) @(negedge clk);
    chk("t4_collide_sticky", 32'(oCollide), 1);
    chk("t4_group_done", n_gd - gd0, 1);
    chk("t4_queue_drained", exp_q.size(), 0);
    chk("t4_errcnt", 32'(oErrCnt), ERRCNT_ON ? 32'd1 : 32'd0);

    // Reset mid-word abandons the group; writes resume from address 0 after a new marker
    do_reset("rst4");
    iSwitch = 1'b0;
    gd0 = n_gd;
    for (int i = 0; i < 5; i++) begin
      d = 12'h100 + WB'(i);
      push_exp(1'b1, i, d);
      send_word(d, i == 0);
    end
    part = 12'hABC;
    for (int i = WB - 1; i > WB - 7; i--) send_bit(part[i], 1'b0);
    chk("t5_addr_before_reset", 32'(oAddr), 5);
    do_reset("t5_in_reset");
    for (int i = 0; i < 3; i++) begin
      d = 12'h5A0 + WB'(i);
      push_exp(1'b1, i, d);
      send_word(d, i == 0);
    end
    repeat (4) @(negedge clk);
    chk("t5_queue_drained", exp_q.size(), 0);
    chk("t5_no_group_done", n_gd - gd0, 0);

    // 300 back-to-back sync errors saturate the counter (or leave it at 0 when disabled)
    do_reset("rst5");
    se0 = n_se;
    for (int i = 0; i < 301; i++) send_bit(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("t6_sync_err_pulses", n_se - se0, 300);
    chk("t6_errcnt", 32'(oErrCnt), ERRCNT_ON ? 32'd255 : 32'd0);
    chk("t6_queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_writer.md
SERIAL_WRITER -- requirements
Module: serial_writer

Interface
REQ-001 Parameter WORD_BITS, default 12: bits per data word.
REQ-002 Parameter GROUP_LEN, default 1024: words per group, equal to grpBuffer depth.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 iSCLK  input  1  serial bit clock, asynchronous to clk.
REQ-006 iSFM  input  1  frame marker, asynchronous; high at the bit clock edge of a group's first bit.
REQ-007 iSDAT  input  1  serial data, asynchronous, MSB first.
REQ-008 iSwitch  input  1  buffer index currently being read downstream (the frame former's oSwitch).
REQ-009 oData  output  WORD_BITS  assembled word to both buffers' data ports.
REQ-010 oAddr  output  10  write address to both buffers' wraddress.
REQ-011 oWrEn0 / oWrEn1  output  1 each  write strobe to buffer m0 / m1.
REQ-012 oGroupDone  output  1  one-cycle pulse after the last word of a group is written.
REQ-013 oSyncErr  output  1  one-cycle pulse on marker received mid-group.
REQ-014 oCollide  output  1  sticky flag: reader switched onto the buffer being written.
REQ-015 oErrCnt  output  8  error counter (see Configuration).

Function
REQ-016 iSCLK, iSFM, iSDAT each SHALL pass through a 2-flop synchronizer; a rising edge of synchronized iSCLK (high after low) SHALL be one bit event.
REQ-017 At each bit event, synchronized iSDAT and iSFM SHALL be sampled together.
REQ-018 Inputs are valid only when iSCLK high and low phases each last at least 3 clk cycles; faster input is out of scope.
REQ-019 States: HUNT and SHIFT; reset state HUNT.
REQ-020 HUNT: bit events with iSFM=0 SHALL be ignored.
REQ-021 HUNT: a bit event with iSFM=1 SHALL store the bit as word MSB, set bit count to 1 and address to 0, latch write buffer wb = ~iSwitch, and enter SHIFT.
REQ-022 SHIFT: each bit event with iSFM=0 SHALL shift the bit in at the LSB and increment the bit count.
REQ-023 When the bit count reaches WORD_BITS, oData SHALL hold the word and exactly one of oWrEn0/oWrEn1 (selected by wb) SHALL be high for exactly one clk cycle in the following cycle, with oAddr stable in that cycle; the bit count then returns to 0.
REQ-024 The write strobe SHALL occur 3 to 4 clk cycles after the raw iSCLK rising edge carrying the last bit.
REQ-025 oAddr SHALL increment by 1 in the cycle after each write strobe.
REQ-026 Write at address GROUP_LEN-1 SHALL be followed next cycle by a oGroupDone pulse, oAddr returning to 0, and transition to HUNT.
REQ-027 SHIFT: a bit event with iSFM=1 SHALL discard the partial word and group, pulse oSyncErr, and restart exactly as in REQ-021 (same cycle, new wb latched).
REQ-028 Marker on the bit that completes a group's last word SHALL be treated as REQ-027 (completion not written, oGroupDone not pulsed).
REQ-029 wb SHALL NOT change inside a group; oCollide SHALL set in any SHIFT cycle with iSwitch == wb and stay high until reset.
REQ-030 oWrEn0 and oWrEn1 SHALL never be high in the same cycle.

Reset
REQ-031 reset low SHALL immediately force: state HUNT, synchronizers 0, bit count 0, oData 0, oAddr 0, oWrEn0/1 0, oGroupDone 0, oSyncErr 0, oCollide 0, oErrCnt 0, wb 0.
REQ-032 Reset asserted mid-group SHALL abandon the group with no further write strobes; after release, a write resumes only after a new marker.

Configuration
REQ-033 Macro SERIAL_WRITER_ERRCNT_EN defined: oErrCnt SHALL increment by 1 on every oSyncErr pulse and every cycle oCollide rises, saturating at 255.
REQ-034 Macro undefined: oErrCnt SHALL be constant 0 and no counter logic SHALL exist; all other behaviour is identical.

Verification
REQ-035 Group 1024 words 0x000..0x3FF, marker on first bit, iSwitch=0, iSCLK period 8 clk -> 1024 oWrEn1 pulses, oAddr 0..1023, oData equal to address, one oGroupDone, oWrEn0 never high.
REQ-036 Idle bits with iSFM=0 in HUNT, then group with iSwitch=1 -> no strobes before marker; all writes on oWrEn0.
REQ-037 Marker at bit 5 of word 7 -> oSyncErr pulse, no write of word 7, next write at oAddr 0 with new word; with macro, oErrCnt=1.
REQ-038 iSwitch toggles 0->1 at word 300 -> oCollide set, remains 1 through group end; writes stay on oWrEn1.
REQ-039 reset low during word 500, released, group restarted -> all outputs 0 during reset, first write after release at oAddr 0.
REQ-040 Macro defined, 300 forced sync errors -> oErrCnt saturates at 255; macro undefined -> oErrCnt stays 0.
